dac_serial_tx: RTL and testbench



---
 rtl/dac_serial_tx_if.sv | 11 +
 rtl/dac_serial_tx.sv | 55 +++++
 tb/tb_dac_serial_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/dac_serial_tx_if.sv
// dac_serial_tx_if: sample inputs and serial DAC outputs of dac_serial_tx.
interface dac_serial_tx_if #(parameter int DATA_W = 16);
  logic signed [DATA_W-1:0] leftIn;
  logic signed [DATA_W-1:0] rightIn;
  logic DL;
  logic DR;
  logic LL;
  logic LR;
  modport master (output leftIn, rightIn, input DL, DR, LL, LR);
  modport slave (input leftIn, rightIn, output DL, DR, LL, LR);
endinterface

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: stereo serial DAC output stage, one MSB-first word per FRAME_LEN-cycle frame.
// Define DAC_OFFSET_BINARY_EN to send offset-binary (MSB inverted) instead of two's complement.
module dac_serial_tx #(
  parameter int DATA_W = 16,
  parameter int FRAME_LEN = 256
) (
  input logic clk_12,
  input logic reset_n,
  dac_serial_tx_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [DATA_W-1:0] MSB_M = {1'b1, {(DATA_W-1){1'b0}}};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shl_q, shl_d, shr_q, shr_d, smp_l, smp_r;
  logic dl_q, dl_d, dr_q, dr_d, stb_q, stb_d, cap;
`ifdef DAC_OFFSET_BINARY_EN
  assign smp_l = bus.leftIn ^ MSB_M;
  assign smp_r = bus.rightIn ^ MSB_M;
`else
  assign smp_l = bus.leftIn;
  assign smp_r = bus.rightIn;
`endif
  // outputs are computed from the next count so they are registered yet aligned to cnt
  always_comb begin
    cnt_d = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + 1'b1;
    cap = (cnt_q == '0);
    stb_d = (cnt_d != '0) && (cnt_d <= CW'(DATA_W));
    shl_d = cap ? smp_l << 1 : shl_q << 1;
    shr_d = cap ? smp_r << 1 : shr_q << 1;
    dl_d = stb_d & (cap ? smp_l[DATA_W-1] : shl_q[DATA_W-1]);
    dr_d = stb_d & (cap ? smp_r[DATA_W-1] : shr_q[DATA_W-1]);
  end
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      shl_q <= '0;
      shr_q <= '0;
      dl_q <= 1'b0;
      dr_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      shl_q <= shl_d;
      shr_q <= shr_d;
      dl_q <= dl_d;
      dr_q <= dr_d;
      stb_q <= stb_d;
    end
  end
  assign bus.DL = dl_q;
  assign bus.DR = dr_q;
  assign bus.LL = stb_q;
  assign bus.LR = stb_q;
  MSB_M_unused_guard: assert property (@(posedge clk_12) MSB_M[DATA_W-1]);
endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: scoreboard bench; a receiver model rebuilds words on strobe falls.
module tb_dac_serial_tx;
  typedef struct { logic [15:0] l; logic [15:0] r; } word_t;
  logic clk_12 = 1'b0;
  logic reset_n = 1'b1;
  int n = 0;
  int errs = 0;
  int words = 0;
  int idle_bad = 0;
  word_t exp_q[$];
  dac_serial_tx_if #(.DATA_W(16)) bus ();
  dac_serial_tx #(.DATA_W(16), .FRAME_LEN(256)) dut (.clk_12(clk_12), .reset_n(reset_n), .bus(bus));
  always #5 clk_12 = ~clk_12;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] enc(input logic [15:0] v);
`ifdef DAC_OFFSET_BINARY_EN
    return v ^ 16'h8000;
`else
    return v;
`endif
  endfunction
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    word_t w;
    w.l = enc(l);
    w.r = enc(r);
    exp_q.push_back(w);
  endtask
  task automatic edges(input int k);
    repeat (k) @(posedge clk_12);
  endtask
  int cyc = 0;
  int hi = 0;
  int last = -1;
  logic prev = 1'b0;
  logic [15:0] rl = '0, rr = '0;
  always @(negedge clk_12) begin
    word_t w;
    cyc++;
    if (!reset_n) begin
      hi = 0;
      prev = 1'b0;
      last = -1;
    end else begin
      if (bus.LL) begin
        rl = {rl[14:0], bus.DL};
        rr = {rr[14:0], bus.DR};
        hi++;
      end else if (bus.DL || bus.DR) idle_bad++;
      if (bus.LR !== bus.LL) idle_bad++;
      if (prev && !bus.LL) begin
        chk("strobe_len", hi, 16);
        if (exp_q.size() == 0) begin
          n++;
          errs++;
          $display("FAIL unexpected_word: got %0h/%0h expected none", rl, rr);
        end else begin
          w = exp_q.pop_front();
          chk("left_word", rl, w.l);
          chk("right_word", rr, w.r);
        end
        if (last >= 0) chk("frame_period", cyc - last, 256);
        last = cyc;
        words++;
        hi = 0;
      end
      prev = bus.LL;
    end
  end
  initial begin
    bus.leftIn = 16'h0009;
    bus.rightIn = 16'h0006;
    #1 reset_n = 1'b0;
    #1 chk("reset_outs", {bus.DL, bus.DR, bus.LL, bus.LR}, 0);
    edges(2);
    @(negedge clk_12);
    push(16'h0009, 16'h0006);
    reset_n = 1'b1;
    edges(20);
    #1 bus.leftIn = 16'h0004;
    bus.rightIn = 16'h0008;
    push(16'h0004, 16'h0008);
    edges(260);
    #1 bus.leftIn = 16'h8000;
    bus.rightIn = 16'h7FFF;
    push(16'h8000, 16'h7FFF);
    edges(260);
    #1 bus.leftIn = 16'h1234;
    bus.rightIn = 16'hABCD;
    edges(236);
    #2 chk("pre_reset_ll", bus.LL, 1);
    reset_n = 1'b0;
    #1 chk("async_reset_outs", {bus.DL, bus.DR, bus.LL, bus.LR}, 0);
    edges(2);
    @(negedge clk_12);
    bus.leftIn = 16'h5A5A;
    bus.rightIn = 16'hA5A5;
    push(16'h5A5A, 16'hA5A5);
    push(16'h5A5A, 16'hA5A5);
    reset_n = 1'b1;
    edges(300);
    #1 chk("idle_violations", idle_bad, 0);
    chk("pending_words", exp_q.size(), 0);
    chk("word_count", words, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
